// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
//   Consumes the UART receiver byte stream and frames it as
//   SYNC, LEN, LEN payload bytes, CSUM. Payload bytes are forwarded one
//   clock after they arrive; every started frame that is not cut short by
//   reset ends with exactly one o_Frame_Done pulse carrying its status.
//
// Handshake: all strobes here (i_RX_DV, o_Data_DV, o_Frame_Done) are
//   valid-only, one cycle wide, with no ready/backpressure. Data or status
//   is meaningful only in the cycle its strobe is high and must be taken
//   in that cycle. When a strobe is low, its companion outputs are driven to 0.
//
// The FSM state is held in the signal "state" (type state_t), which
// checkers can bind to directly. o_Busy is its registered "not IDLE" view.

module uart_rx_frame_parser #(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         MAX_LEN      = 64,
   parameter int         TIMEOUT_CLKS = 8680
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   output logic       o_Data_DV,
   output logic [7:0] o_Data_Byte,
   output logic       o_Data_Last,
   output logic       o_Frame_Done,
   output logic [1:0] o_Frame_Err,
   output logic       o_Busy
);

   // Status codes reported with o_Frame_Done.
   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_LEN     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // The idle timer must be able to hold TIMEOUT_CLKS-1; expiry is flagged
   // when it sits at that value with no byte arriving.
   localparam int                   TIMER_W    = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]           MAX_LEN_B  = 8'(MAX_LEN);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LEN     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CSUM    = 2'd3
   } state_t;

   // Current registered state and working registers.
   state_t             state;
   logic [7:0]         sum;
   logic [7:0]         count;
   logic [TIMER_W-1:0] timer;

   // Next-cycle values computed combinationally.
   state_t             state_n;
   logic [7:0]         sum_n;
   logic [7:0]         count_n;
   logic [TIMER_W-1:0] timer_n;
   logic               data_dv_n;
   logic [7:0]         data_byte_n;
   logic               data_last_n;
   logic               frame_done_n;
   logic [1:0]         frame_err_n;
   logic               busy_n;

   // Inter-byte gap has run out: only possible while a frame is open and no
   // byte shows up this cycle (a byte on the expiry cycle takes priority).
   logic               timeout;

   assign timeout = (state != S_IDLE) && !i_RX_DV && (timer == TIMER_LAST);

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state;
      sum_n        = sum;
      count_n      = count;
      data_dv_n    = 1'b0;
      data_byte_n  = 8'h00;
      data_last_n  = 1'b0;
      frame_done_n = 1'b0;
      frame_err_n  = ERR_OK;

      // Timer only runs between bytes of an open frame.
      if (state == S_IDLE || i_RX_DV) begin
         timer_n = '0;
      end else begin
         timer_n = timer + TIMER_W'(1);
      end

      case (state)
         S_IDLE: begin
            // Anything other than the marker is line noise; drop it.
            if (i_RX_DV && i_RX_Byte == SYNC_BYTE) begin
               state_n = S_LEN;
            end
         end

         S_LEN: begin
            if (i_RX_DV) begin
               if (i_RX_Byte == 8'h00 || i_RX_Byte > MAX_LEN_B) begin
                  frame_done_n = 1'b1;
                  frame_err_n  = ERR_LEN;
                  state_n      = S_IDLE;
               end else begin
                  // The checksum covers LEN itself, so seed it here.
                  count_n = i_RX_Byte;
                  sum_n   = i_RX_Byte;
                  state_n = S_PAYLOAD;
               end
            end
         end

         S_PAYLOAD: begin
            if (i_RX_DV) begin
               data_dv_n   = 1'b1;
               data_byte_n = i_RX_Byte;
               sum_n       = sum + i_RX_Byte;
               count_n     = count - 8'd1;
               if (count == 8'd1) begin
                  data_last_n = 1'b1;
                  state_n     = S_CSUM;
               end
            end
         end

         S_CSUM: begin
            if (i_RX_DV) begin
               frame_done_n = 1'b1;
               frame_err_n  = (i_RX_Byte == sum) ? ERR_OK : ERR_CSUM;
               state_n      = S_IDLE;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Timeout can only fire on a cycle with no byte, so it never competes
      // with the per-state decisions above.
      if (timeout) begin
         frame_done_n = 1'b1;
         frame_err_n  = ERR_TIMEOUT;
         state_n      = S_IDLE;
      end

      busy_n = (state_n != S_IDLE);
   end

   // State, working registers and registered outputs.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state        <= S_IDLE;
         sum          <= 8'h00;
         count        <= 8'h00;
         timer        <= '0;
         o_Data_DV    <= 1'b0;
         o_Data_Byte  <= 8'h00;
         o_Data_Last  <= 1'b0;
         o_Frame_Done <= 1'b0;
         o_Frame_Err  <= 2'd0;
         o_Busy       <= 1'b0;
      end else begin
         state        <= state_n;
         sum          <= sum_n;
         count        <= count_n;
         timer        <= timer_n;
         o_Data_DV    <= data_dv_n;
         o_Data_Byte  <= data_byte_n;
         o_Data_Last  <= data_last_n;
         o_Frame_Done <= frame_done_n;
         o_Frame_Err  <= frame_err_n;
         o_Busy       <= busy_n;
      end
   end

   // The checksum is its own byte, so the last payload byte and the frame
   // status can never be reported in the same cycle.
   a_last_not_done : assert property (@(posedge i_Clock) !(o_Data_Last && o_Frame_Done));

   // Last is only ever a qualifier of a data strobe.
   a_last_with_dv : assert property (@(posedge i_Clock) o_Data_Last |-> o_Data_DV);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: directed byte frames, a frame-level
// reference model compared every cycle, and hand-computed literal
// expectations for payload bytes and frame status.

module tb_uart_rx_frame_parser;

   localparam int         TIMEOUT = 8680;
   localparam int         MAXLEN  = 64;
   localparam logic [7:0] SYNC    = 8'hA5;

   logic       clk;
   logic       rst;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       data_dv;
   logic [7:0] data_byte;
   logic       data_last;
   logic       frame_done;
   logic [1:0] frame_err;
   logic       busy;

   uart_rx_frame_parser #(
      .SYNC_BYTE   (SYNC),
      .MAX_LEN     (MAXLEN),
      .TIMEOUT_CLKS(TIMEOUT)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_RX_DV     (rx_dv),
      .i_RX_Byte   (rx_byte),
      .o_Data_DV   (data_dv),
      .o_Data_Byte (data_byte),
      .o_Data_Last (data_last),
      .o_Frame_Done(frame_done),
      .o_Frame_Err (frame_err),
      .o_Busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- literal expectations ----------------
   logic [8:0] exp_q[$];   // {last, byte} for each forwarded payload byte
   logic [1:0] err_q[$];   // status for each finished frame

   task automatic expect_data(input logic [7:0] b, input logic last);
      exp_q.push_back({last, b});
   endtask

   task automatic expect_done(input logic [1:0] e);
      err_q.push_back(e);
   endtask

   // ---------------- frame-level reference model ----------------
   // Bytes after SYNC are collected in order; position within the frame
   // decides their meaning (1st = LEN, then payload, then checksum).
   logic [7:0] frm[$];
   bit         in_frame = 0;
   int         gap = 0;
   int         cyc = 0;
   logic       m_dv = 0, m_last = 0, m_done = 0, m_busy = 0;
   logic [7:0] m_byte = 0;
   logic [1:0] m_err = 0;

   always @(posedge clk) begin
      int n;
      int flen;
      int s;
      m_dv = 0; m_byte = 0; m_last = 0; m_done = 0; m_err = 0;
      if (rst) begin
         in_frame = 0;
         frm.delete();
         gap = 0;
      end else if (rx_dv) begin
         gap = 0;
         if (!in_frame) begin
            if (rx_byte == SYNC) begin
               in_frame = 1;
               frm.delete();
            end
         end else begin
            frm.push_back(rx_byte);
            n = frm.size();
            flen = int'(frm[0]);
            if (n == 1) begin
               if (flen == 0 || flen > MAXLEN) begin
                  m_done = 1; m_err = 2; in_frame = 0;
               end
            end else if (n <= flen + 1) begin
               m_dv = 1; m_byte = rx_byte; m_last = (n == flen + 1);
            end else begin
               s = 0;
               for (int i = 0; i < n - 1; i++) s += int'(frm[i]);
               m_done = 1;
               m_err = ((s % 256) == int'(rx_byte)) ? 2'd0 : 2'd1;
               in_frame = 0;
            end
         end
      end else if (in_frame) begin
         gap++;
         if (gap == TIMEOUT) begin
            m_done = 1; m_err = 3; in_frame = 0;
         end
      end else begin
         gap = 0;
      end
      m_busy = in_frame;
      cyc++;
   end

   // ---------------- scoreboard / compare ----------------
   logic [8:0] exp_d;
   logic [1:0] exp_e;
   always @(negedge clk) begin
      if (cyc > 0) begin
         check("data_dv",    data_dv,    m_dv);
         check("data_byte",  data_byte,  m_byte);
         check("data_last",  data_last,  m_last);
         check("frame_done", frame_done, m_done);
         check("frame_err",  frame_err,  m_err);
         check("busy",       busy,       m_busy);
         if (data_dv === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_data", 1, 0);
            end else begin
               exp_d = exp_q.pop_front();
               check("lit_data", {data_last, data_byte}, exp_d);
            end
         end
         if (frame_done === 1'b1) begin
            if (err_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_e = err_q.pop_front();
               check("lit_err", frame_err, exp_e);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Strobes one byte; the next send() lands idle+2 edges later, so there
   // are idle+1 quiet cycles between strobes.
   task automatic send(input logic [7:0] b, input int idle = 1);
      @(posedge clk); #1;
      rx_dv = 1'b1; rx_byte = b;
      @(posedge clk); #1;
      rx_dv = 1'b0; rx_byte = 8'h00;
      repeat (idle) @(posedge clk);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", {data_dv, data_byte, data_last, frame_done, frame_err, busy}, 14'h0);

      // 1. good 3-byte frame: 03+11+22+33 = 0x69
      expect_data(8'h11, 0); expect_data(8'h22, 0); expect_data(8'h33, 1); expect_done(2'd0);
      send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69, 3);
      @(negedge clk);
      check("busy_after_ok", busy, 0);

      // same frame with 0x79 as checksum is wrong (sum is 0x69)
      expect_data(8'h11, 0); expect_data(8'h22, 0); expect_data(8'h33, 1); expect_done(2'd1);
      send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h79, 3);

      // 2. bad checksum (needs 0x32)
      expect_data(8'h10, 0); expect_data(8'h20, 1); expect_done(2'd1);
      send(SYNC); send(8'h02); send(8'h10); send(8'h20); send(8'h00, 3);

      // 3. illegal lengths: 0, 65, 255
      expect_done(2'd2); send(SYNC); send(8'h00, 3);
      expect_done(2'd2); send(SYNC); send(8'h41, 3);
      expect_done(2'd2); send(SYNC); send(8'hFF, 3);

      // LEN = MAX_LEN accepted: payload 0..63, sum = 0x40 + 2016 = 0x20 mod 256
      expect_done(2'd0);
      send(SYNC); send(8'h40);
      for (int i = 0; i < 64; i++) begin
         expect_data(8'(i), i == 63);
         send(8'(i));
      end
      send(8'h20, 3);

      // 4. timeout after partial payload
      expect_data(8'h10, 0); expect_done(2'd3);
      send(SYNC); send(8'h02); send(8'h10, TIMEOUT + 5);
      @(negedge clk);
      check("busy_after_timeout", busy, 0);
      // SYNC value as payload is plain data: 01 + A5 = A6
      expect_data(8'hA5, 1); expect_done(2'd0);
      send(SYNC); send(8'h01); send(8'hA5); send(8'hA6, 3);

      // byte arriving exactly on the expiry cycle wins: 01 + 5A = 5B
      expect_data(8'h5A, 1); expect_done(2'd0);
      send(SYNC); send(8'h01, TIMEOUT - 2); send(8'h5A); send(8'h5B, 3);

      // 5. noise before SYNC is dropped; sum wraps 01 + FF = 00
      expect_data(8'hFF, 1); expect_done(2'd0);
      send(8'h00); send(8'hFF); send(8'h37);
      send(SYNC); send(8'h01); send(8'hFF); send(8'h00, 3);

      // 6. reset mid-frame: no status pulse
      expect_data(8'h01, 0);
      send(SYNC); send(8'h04); send(8'h01);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("busy_after_reset", busy, 0);
      idle_cycles(3);
      // following good frame: 01 + 07 = 08
      expect_data(8'h07, 1); expect_done(2'd0);
      send(SYNC); send(8'h01); send(8'h07); send(8'h08, 5);

      @(negedge clk);
      check("data_queue_drained", exp_q.size(), 0);
      check("err_queue_drained",  err_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
